// File: rtl/circ_buf_reader.sv
// Consumer end of the circular slot buffer: gathers READ_SIZE consecutive slots into a registered valid/ready beat.
// One cycle from count >= READ_SIZE to rd_valid; while rd_ready is low the beat, rd_ptr and gathering are frozen.
module circ_buf_reader #(
    parameter int SIZE       = 8,
    parameter int WRITE_SIZE = 2,
    parameter int READ_SIZE  = 2,
    parameter int DATA_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          wr_en,
    input  logic [SIZE*DATA_W-1:0]        buf_data,
    input  logic                          rd_ready,
    output logic                          rd_valid,
    output logic [READ_SIZE*DATA_W-1:0]   rd_data,
    output logic [SIZE-1:0]               rd_mask,
    output logic [$clog2(SIZE)-1:0]       rd_ptr,
    output logic [$clog2(SIZE+1)-1:0]     count,
    output logic                          full,
    output logic                          empty,
    output logic                          ovf
);

    localparam int PW = $clog2(SIZE);
    localparam int CW = $clog2(SIZE+1);

    logic [DATA_W-1:0]           slot [SIZE];
    logic [PW-1:0]               gidx [READ_SIZE];
    logic [READ_SIZE*DATA_W-1:0] gather;
    logic [31:0]                 cnt_ext;
    logic [31:0]                 cnt_next;
    logic [31:0]                 ptr_sum;
    logic [PW-1:0]               ptr_next;
    logic                        load;
    logic                        wr_ok;

    for (genvar k = 0; k < SIZE; k++) begin : g_slot
        assign slot[k] = buf_data[k*DATA_W +: DATA_W];
    end

    // Slot indices are reduced modulo SIZE from a 32-bit sum so non-power-of-two sizes wrap correctly.
    for (genvar j = 0; j < READ_SIZE; j++) begin : g_gather
        assign gidx[j] = PW'((32'(rd_ptr) + 32'(j)) % 32'(SIZE));
        assign gather[j*DATA_W +: DATA_W] = slot[gidx[j]];
    end

    assign ptr_sum  = 32'(rd_ptr) + 32'(READ_SIZE);
    assign ptr_next = PW'(ptr_sum % 32'(SIZE));

    assign cnt_ext = 32'(count);
    assign full    = cnt_ext > 32'(SIZE - WRITE_SIZE);
    assign empty   = (count == '0);
    assign wr_ok   = wr_en & ~full;

    // Load looks only at the registered count; same-cycle writes become eligible next cycle.
    assign load     = (cnt_ext >= 32'(READ_SIZE)) && (!rd_valid || rd_ready);
    assign cnt_next = cnt_ext + (wr_ok ? 32'(WRITE_SIZE) : 32'd0)
                              - (load  ? 32'(READ_SIZE)  : 32'd0);

    always_comb begin
        rd_mask = '0;
        if (load) begin
            for (int i = 0; i < READ_SIZE; i++) begin
                rd_mask[gidx[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            ovf      <= 1'b0;
        end else begin
            count <= CW'(cnt_next);
            if (wr_en && full) begin
                ovf <= 1'b1;
            end
            if (load) begin
                rd_data  <= gather;
                rd_valid <= 1'b1;
                rd_ptr   <= ptr_next;
            end else if (rd_valid && rd_ready) begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule
